conv1_mac_scheduler: RTL and testbench
======================================

# conv1_mac_scheduler

Sequential scheduler for the first convolution layer. It replaces the fully combinational 32x32 / 5x5 / 2-channel convolution with a single time-shared multiply-accumulate. It walks every output pixel of both 28x28 feature maps, issues image and kernel buffer reads, accumulates the 25 products and writes each result to the feature-map buffer. It sits between the padded-image/kernel SRAMs and the feature-map SRAM and is kicked off by the layer controller via start/done.

## Interface
- IMG_W, 32, padded image side length
- K, 5, kernel side length
- N_CH, 2, number of output channels / kernels
- BITWIDTH, 32, pixel, weight and accumulator width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  start one full layer pass (sampled in IDLE only)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last feature-map write
- img_rd_en  out  1  image buffer read strobe
- img_addr  out  10  (r+kr)*IMG_W + (c+kc)
- img_rdata  in  BITWIDTH  image data, valid 1 cycle after img_rd_en
- ker_rd_en  out  1  kernel buffer read strobe
- ker_addr  out  6  ch*K*K + kr*K + kc
- ker_rdata  in  BITWIDTH  weight data, valid 1 cycle after ker_rd_en
- fm_we  out  1  feature-map write request
- fm_ready  in  1  feature-map buffer accepts write this cycle
- fm_addr  out  11  ch*784 + r*28 + c
- fm_wdata  out  BITWIDTH  accumulated result

## Operation
- OUT_W = IMG_W-K+1 = 28. Loop order: ch (outer), r, c, then kr, kc (inner).
- States and transitions:
  - IDLE: start=1 -> READ, counters zeroed.
  - READ: 25 cycles, one tap per cycle; last tap -> DRAIN.
  - DRAIN: 1 cycle, adds the final product -> WRITE.
  - WRITE: hold fm_we=1; fm_ready=1 -> next pixel's READ, or DONE after pixel (1,27,27).
  - DONE: 1 cycle, done=1 -> IDLE.
- Both read enables are high in every READ cycle and low elsewhere. Both buffers are read with the same tap index.
- Accumulator is cleared on entry to READ for every pixel. In READ cycles 2..25 and in DRAIN it adds img_rdata*ker_rdata from the previous cycle's read.
- Arithmetic is unsigned. Product is truncated to the low BITWIDTH bits. Accumulation wraps modulo 2^BITWIDTH; no saturation.
- fm_wdata = accumulator during WRITE. fm_addr and fm_wdata stay stable while fm_we=1 and fm_ready=0.
- Boundary conditions:
  - start while busy: ignored.
  - start held high through DONE: a new pass begins from IDLE on the next cycle.
  - fm_ready low indefinitely: the scheduler stalls in WRITE with no reads issued.
  - rst_n asserted mid-pass: immediate return to IDLE with all outputs zero. No partial write completes, and done is not pulsed.

## Timing
- Reset values: busy=0, done=0, img_rd_en=0, ker_rd_en=0, fm_we=0, img_addr=0, ker_addr=0, fm_addr=0, fm_wdata=0.
- start sampled at edge E0 -> READ and busy=1 from cycle 1.
- With fm_ready held high, each pixel takes exactly 27 cycles: 25 READ, 1 DRAIN, 1 WRITE.
- The first write (fm_addr=0) is accepted at edge 27.
- done pulses in cycle 2*784*27+1 = 42337; busy falls in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset and idle: rst_n low, then high, no start -> all outputs 0 for 100 cycles. Then start=1 for one cycle -> busy=1 next cycle, first img_addr=0 and ker_addr=0.
- Directed image, all-ones kernels: pixel (2,2)=1, (2,3)=2, (29,2)=1, all other pixels 0; kernels all 1.
  - Writes fm[0]=3 and fm[784]=3 (pixel 0,0).
  - fm[27*28]=1 (pixel 27,0).
  - fm[5*28+5]=0.
  - done at cycle 42337.
- Address sequence: for pixel (ch=1, r=3, c=4), the 25 img_addr values run 100..104, 132..136, ..., 228..232. ker_addr runs 25..49.
- Back-pressure: fm_ready low for 10 cycles on the first write -> fm_we, fm_addr=0 and fm_wdata held constant. Total latency grows by exactly 10.
- Wrap arithmetic: all pixels 0xFFFF_FFFF, weights 2 -> every fm_wdata = (25*0xFFFF_FFFE) mod 2^32 = 0xFFFF_FFCE.
- Reset mid-pass and restart: rst_n pulsed low during pixel 500 -> outputs 0, no done, no further writes. start pulsed during busy -> ignored. A new start then completes a full pass with correct results.

Source files
------------

// File: rtl/conv1_mac_scheduler_if.sv
// Bus between the conv1 MAC scheduler and its surroundings: the start/done
// handshake, the image and kernel read ports, and the feature-map write port.
interface conv1_mac_scheduler_if #(
    parameter int BITWIDTH = 32
);
    logic                start;
    logic                busy;
    logic                done;
    logic                img_rd_en;
    logic [9:0]          img_addr;
    logic [BITWIDTH-1:0] img_rdata;
    logic                ker_rd_en;
    logic [5:0]          ker_addr;
    logic [BITWIDTH-1:0] ker_rdata;
    logic                fm_we;
    logic                fm_ready;
    logic [10:0]         fm_addr;
    logic [BITWIDTH-1:0] fm_wdata;

    // Controller and buffer side
    modport master (
        output start, img_rdata, ker_rdata, fm_ready,
        input  busy, done, img_rd_en, img_addr, ker_rd_en, ker_addr,
               fm_we, fm_addr, fm_wdata
    );

    // Scheduler side
    modport slave (
        input  start, img_rdata, ker_rdata, fm_ready,
        output busy, done, img_rd_en, img_addr, ker_rd_en, ker_addr,
               fm_we, fm_addr, fm_wdata
    );
endinterface

// File: rtl/conv1_mac_scheduler.sv
// Time-shared single-MAC scheduler for conv layer 1: walks ch, r, c, kr, kc,
// reads image/kernel buffers one tap per cycle, accumulates the 25 products
// and writes each output pixel to the feature-map buffer.
module conv1_mac_scheduler #(
    parameter int IMG_W    = 32,
    parameter int K        = 5,
    parameter int N_CH     = 2,
    parameter int BITWIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    conv1_mac_scheduler_if.slave bus
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int KW    = (K > 1)     ? $clog2(K)     : 1;
    localparam int PW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int CW    = (N_CH > 1)  ? $clog2(N_CH)  : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [PW-1:0] P_LAST = PW'(OUT_W - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N_CH - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t r_state, w_state_nxt;
    logic [CW-1:0]       r_ch, w_ch_nxt;
    logic [PW-1:0]       r_row, w_row_nxt, r_col, w_col_nxt;
    logic [KW-1:0]       r_kr, w_kr_nxt, r_kc, w_kc_nxt;
    logic [BITWIDTH-1:0] r_acc, w_acc_nxt, w_prod;
    logic [9:0]          w_img_addr_nxt;
    logic [5:0]          w_ker_addr_nxt;
    logic [10:0]         w_fm_addr_nxt;
    logic                w_last_pixel;

    logic                r_busy, r_done, r_img_rd_en, r_ker_rd_en, r_fm_we;
    logic [9:0]          r_img_addr;
    logic [5:0]          r_ker_addr;
    logic [10:0]         r_fm_addr;
    logic [BITWIDTH-1:0] r_fm_wdata;

    // Unsigned product, truncated to BITWIDTH
    assign w_prod       = bus.img_rdata * bus.ker_rdata;
    assign w_last_pixel = (r_ch == C_LAST) && (r_row == P_LAST) && (r_col == P_LAST);

    // Addresses are derived from the next-cycle counters so they can be registered
    assign w_img_addr_nxt = 10'((32'(w_row_nxt) + 32'(w_kr_nxt)) * 32'(IMG_W)
                                + 32'(w_col_nxt) + 32'(w_kc_nxt));
    assign w_ker_addr_nxt = 6'(32'(w_ch_nxt) * 32'(K * K) + 32'(w_kr_nxt) * 32'(K)
                               + 32'(w_kc_nxt));
    assign w_fm_addr_nxt  = 11'(32'(w_ch_nxt) * 32'(OUT_W * OUT_W)
                                + 32'(w_row_nxt) * 32'(OUT_W) + 32'(w_col_nxt));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, loop counters and accumulator
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_kr_nxt    = r_kr;
        w_kc_nxt    = r_kc;
        w_acc_nxt   = r_acc;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = READ;
                    w_ch_nxt    = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_kr_nxt    = '0;
                    w_kc_nxt    = '0;
                    w_acc_nxt   = '0;
                end
            end
            READ: begin
                // Data returned this cycle belongs to the previous tap; tap 0 has none yet
                if (r_kr != '0 || r_kc != '0) w_acc_nxt = r_acc + w_prod;
                if (r_kc == K_LAST) begin
                    w_kc_nxt = '0;
                    if (r_kr == K_LAST) begin
                        w_kr_nxt    = '0;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_kr_nxt = r_kr + 1'b1;
                    end
                end else begin
                    w_kc_nxt = r_kc + 1'b1;
                end
            end
            DRAIN: begin
                w_acc_nxt   = r_acc + w_prod;
                w_state_nxt = WRITE;
            end
            WRITE: begin
                if (bus.fm_ready) begin
                    if (w_last_pixel) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = READ;
                        w_acc_nxt   = '0;
                        if (r_col == P_LAST) begin
                            w_col_nxt = '0;
                            if (r_row == P_LAST) begin
                                w_row_nxt = '0;
                                w_ch_nxt  = r_ch + 1'b1;
                            end else begin
                                w_row_nxt = r_row + 1'b1;
                            end
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Loop counters and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_row <= '0;
            r_col <= '0;
            r_kr  <= '0;
            r_kc  <= '0;
            r_acc <= '0;
        end else begin
            r_ch  <= w_ch_nxt;
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_kr  <= w_kr_nxt;
            r_kc  <= w_kc_nxt;
            r_acc <= w_acc_nxt;
        end
    end

    // Registered outputs decoded from the next state; idle fields are driven to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_img_rd_en <= 1'b0;
            r_ker_rd_en <= 1'b0;
            r_img_addr  <= '0;
            r_ker_addr  <= '0;
            r_fm_we     <= 1'b0;
            r_fm_addr   <= '0;
            r_fm_wdata  <= '0;
        end else begin
            r_busy      <= (w_state_nxt == READ) || (w_state_nxt == DRAIN) || (w_state_nxt == WRITE);
            r_done      <= (w_state_nxt == DONE);
            r_img_rd_en <= (w_state_nxt == READ);
            r_ker_rd_en <= (w_state_nxt == READ);
            r_img_addr  <= (w_state_nxt == READ)  ? w_img_addr_nxt : '0;
            r_ker_addr  <= (w_state_nxt == READ)  ? w_ker_addr_nxt : '0;
            r_fm_we     <= (w_state_nxt == WRITE);
            r_fm_addr   <= (w_state_nxt == WRITE) ? w_fm_addr_nxt  : '0;
            r_fm_wdata  <= (w_state_nxt == WRITE) ? w_acc_nxt      : '0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.img_rd_en = r_img_rd_en;
    assign bus.ker_rd_en = r_ker_rd_en;
    assign bus.img_addr  = r_img_addr;
    assign bus.ker_addr  = r_ker_addr;
    assign bus.fm_we     = r_fm_we;
    assign bus.fm_addr   = r_fm_addr;
    assign bus.fm_wdata  = r_fm_wdata;
endmodule

// File: tb/tb_conv1_mac_scheduler.sv
// Bench for conv1_mac_scheduler: buffer models, a convolution reference
// computed straight from the image/kernel arrays, and phased stimulus
// (wrap data, random data with random back-pressure and mid-pass reset,
// directed data with a stalled first write and full-pass timing).
module tb_conv1_mac_scheduler;
    localparam int IMG_W = 32;
    localparam int K     = 5;
    localparam int N_CH  = 2;
    localparam int BW    = 32;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NPIX  = N_CH * OUT_W * OUT_W;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;
    int unsigned e0    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [BW-1:0] img_mem [IMG_W*IMG_W];
    logic [BW-1:0] ker_mem [N_CH*K*K];
    logic [BW-1:0] fm_got  [NPIX];
    logic [BW-1:0] last_wdata = '0;
    int n_wr = 0, n_rd = 0, n_done = 0, stall_cnt = 0;
    int ready_mode = 0;

    conv1_mac_scheduler_if #(.BITWIDTH(BW)) bus ();

    conv1_mac_scheduler #(
        .IMG_W(IMG_W), .K(K), .N_CH(N_CH), .BITWIDTH(BW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffers: data appears one cycle after the strobe
    always @(posedge clk) begin
        if (bus.img_rd_en) bus.img_rdata <= img_mem[bus.img_addr];
        if (bus.ker_rd_en) bus.ker_rdata <= ker_mem[bus.ker_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] ref_pixel(input int idx);
        int ch, r, c;
        logic [BW-1:0] acc;
        ch  = idx / (OUT_W * OUT_W);
        r   = (idx % (OUT_W * OUT_W)) / OUT_W;
        c   = idx % OUT_W;
        acc = '0;
        for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++)
                acc += img_mem[(r + kr) * IMG_W + c + kc] * ker_mem[ch * K * K + kr * K + kc];
        return acc;
    endfunction

    function automatic logic [63:0] out_vec();
        return {bus.busy, bus.done, bus.img_rd_en, bus.ker_rd_en, bus.fm_we,
                bus.img_addr, bus.ker_addr, bus.fm_addr, bus.fm_wdata};
    endfunction

    // Back-pressure driver plus read-address and write-result checker
    always @(negedge clk) begin
        if (!rst_n) begin
            n_wr = 0; n_rd = 0; n_done = 0; stall_cnt = 0;
            bus.fm_ready = 1'b1;
        end else begin
            case (ready_mode)
                1: bus.fm_ready = ($urandom_range(0, 3) != 0);
                2: if (bus.fm_we && n_wr == 0 && stall_cnt < 10) begin
                       bus.fm_ready = 1'b0;
                       stall_cnt++;
                   end else begin
                       bus.fm_ready = 1'b1;
                   end
                default: bus.fm_ready = 1'b1;
            endcase
            if (bus.img_rd_en) begin
                int p, t, ch, r, c, kr, kc;
                p  = (n_rd / (K * K)) % NPIX;
                t  = n_rd % (K * K);
                ch = p / (OUT_W * OUT_W);
                r  = (p % (OUT_W * OUT_W)) / OUT_W;
                c  = p % OUT_W;
                kr = t / K;
                kc = t % K;
                check_val("img_addr", bus.img_addr, (r + kr) * IMG_W + c + kc);
                check_val("ker_addr", bus.ker_addr, ch * K * K + kr * K + kc);
                check_val("ker_rd_en", bus.ker_rd_en, 1);
                n_rd++;
            end
            if (bus.fm_we) begin
                check_val("no_read_in_write", {bus.img_rd_en, bus.ker_rd_en}, 0);
                check_val("reads_per_pixel", n_rd, (n_wr + 1) * K * K);
                check_val("fm_addr", bus.fm_addr, n_wr % NPIX);
                check_val("fm_wdata", bus.fm_wdata, ref_pixel(n_wr % NPIX));
                if (bus.fm_ready) begin
                    fm_got[n_wr % NPIX] = bus.fm_wdata;
                    last_wdata = bus.fm_wdata;
                    n_wr++;
                end
            end
            if (bus.done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        e0 = cyc;
        check_val("first_busy", bus.busy, 1);
        check_val("first_img_addr", {bus.img_rd_en, bus.img_addr}, {1'b1, 10'd0});
        check_val("first_ker_addr", {bus.ker_rd_en, bus.ker_addr}, {1'b1, 6'd0});
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (n_wr < target && n < budget) begin
            tick();
            n++;
        end
        check_val("write_wait_timeout", 64'(n_wr >= target), 1);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_val("reset_outputs", out_vec(), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_val("por_outputs", out_vec(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_val("idle_outputs", out_vec(), 0);
        end

        // Wrap arithmetic: 25 * 0xFFFFFFFE modulo 2^32
        foreach (img_mem[i]) img_mem[i] = 32'hFFFF_FFFF;
        foreach (ker_mem[i]) ker_mem[i] = 32'd2;
        ready_mode = 0;
        start_pass();
        wait_writes(10, 2000);
        check_val("wrap_value", last_wdata, 32'hFFFF_FFCE);
        pulse_reset();

        // Random data, random back-pressure, start while busy, reset at pixel 500
        foreach (img_mem[i]) img_mem[i] = $urandom;
        foreach (ker_mem[i]) ker_mem[i] = $urandom;
        ready_mode = 1;
        start_pass();
        repeat (100) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("busy_after_ignored_start", bus.busy, 1);
        wait_writes(500, 30000);
        pulse_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            check_val("post_reset_idle", out_vec(), 0);
        end
        check_val("post_reset_no_done", n_done, 0);
        check_val("post_reset_no_write", n_wr, 0);

        // Directed image, all-ones kernels, first write stalled 10 cycles
        foreach (img_mem[i]) img_mem[i] = '0;
        foreach (ker_mem[i]) ker_mem[i] = 32'd1;
        img_mem[2 * IMG_W + 2]  = 32'd1;
        img_mem[2 * IMG_W + 3]  = 32'd2;
        img_mem[29 * IMG_W + 2] = 32'd1;
        ready_mode = 2;
        start_pass();
        k = 1;
        while (bus.done !== 1'b1 && k < 43000) begin
            bus.start = (k == 20000) || (k >= 42340);
            tick();
            k = int'(cyc - e0) + 1;
        end
        check_val("done_cycle", k, 2 * 784 * 27 + 1 + 10);
        check_val("busy_at_done", bus.busy, 0);
        check_val("writes_in_pass", n_wr, NPIX);
        check_val("fm0", fm_got[0], 3);
        check_val("fm784", fm_got[784], 3);
        check_val("fm756", fm_got[27 * 28], 1);
        check_val("fm145", fm_got[5 * 28 + 5], 0);
        tick();
        check_val("idle_after_done", {bus.busy, bus.done}, 0);
        tick();
        check_val("restart_busy", bus.busy, 1);
        check_val("restart_img_addr", bus.img_addr, 0);
        bus.start = 1'b0;
        pulse_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
